batcharger_ctrl: RTL and testbench



---
 rtl/batcharger_ctrl.sv | 151 +++++++++++++++
 tb/tb_batcharger_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/batcharger_ctrl.sv
// rtl/batcharger_ctrl.sv - Li-ion charge sequencer (OFF/CHECK/TC/CC/CV/END/FAULT) with qualification and safety timers
// Optional feature macro: BATCHARGER_TEMPMON_EN enables the temperature window fault checks.
module batcharger_ctrl #(
    parameter int ADC_W   = 8,
    parameter int CODE_W  = 8,
    parameter int TIMER_W = 16,
    parameter int QUAL    = 4
) (
    input  logic               clk,
    input  logic               rstz,
    input  logic               en,
    input  logic [ADC_W-1:0]   vbat,
    input  logic [ADC_W-1:0]   ibat,
    input  logic [ADC_W-1:0]   vtemp,
    input  logic [ADC_W-1:0]   vcutoff,
    input  logic [ADC_W-1:0]   vpreset,
    input  logic [ADC_W-1:0]   vrecharge,
    input  logic [ADC_W-1:0]   iend,
    input  logic [ADC_W-1:0]   tmin,
    input  logic [ADC_W-1:0]   tmax,
    input  logic [CODE_W-1:0]  itc,
    input  logic [CODE_W-1:0]  icc,
    input  logic [TIMER_W-1:0] tc_tmax,
    input  logic [TIMER_W-1:0] cv_tmax,
    output logic               tc,
    output logic               cc,
    output logic               cv,
    output logic [CODE_W-1:0]  icode,
    output logic               done,
    output logic               fault,
    output logic [2:0]         state
);
    localparam logic [2:0] S_OFF   = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_TC    = 3'd2;
    localparam logic [2:0] S_CC    = 3'd3;
    localparam logic [2:0] S_CV    = 3'd4;
    localparam logic [2:0] S_END   = 3'd5;
    localparam logic [2:0] S_FAULT = 3'd6;
    localparam logic [3:0] QUAL_SAT  = 4'(QUAL);
    localparam logic [3:0] QUAL_LAST = 4'(QUAL - 1);

    logic [2:0]         state_d;
    logic [3:0]         prog_cnt, prog_cnt_d, temp_cnt, temp_cnt_d;
    logic [TIMER_W-1:0] timer, timer_d, timer_inc, tmax_sel;
    logic               temp_bad, prog_cond, charging, prog_qual, temp_qual, timeout;
    logic               tc_d, cc_d, cv_d, done_d, fault_d;
    logic [CODE_W-1:0]  icode_d;

`ifdef BATCHARGER_TEMPMON_EN
    assign temp_bad = (vtemp < tmin) || (vtemp > tmax);
`else
    logic unused_temp;
    assign unused_temp = ^{vtemp, tmin, tmax};
    assign temp_bad    = 1'b0;
`endif

    // Condition currently monitored by the progression counter depends on the mode.
    always_comb begin
        prog_cond = 1'b0;
        case (state)
            S_TC:    prog_cond = vbat >= vcutoff;
            S_CC:    prog_cond = vbat >= vpreset;
            S_CV:    prog_cond = ibat < iend;
            S_END:   prog_cond = vbat < vrecharge;
            default: prog_cond = 1'b0;
        endcase
        charging  = (state == S_TC) || (state == S_CC) || (state == S_CV);
        tmax_sel  = (state == S_TC) ? tc_tmax : cv_tmax;
        timer_inc = (&timer) ? timer : timer + TIMER_W'(1);
        // Timeout fires on the edge that completes tmax cycles in the mode.
        timeout   = ((state == S_TC) || (state == S_CV)) && (tmax_sel != '0) && (timer_inc >= tmax_sel);
        prog_qual = prog_cond && (prog_cnt >= QUAL_LAST);
        temp_qual = charging && temp_bad && (temp_cnt >= QUAL_LAST);
    end

    always_comb begin
        state_d = state;
        if (!en) begin
            state_d = S_OFF;
        end else begin
            case (state)
                S_OFF:   state_d = S_CHECK;
                S_CHECK: begin
                    if (temp_bad)            state_d = S_FAULT;
                    else if (vbat < vcutoff) state_d = S_TC;
                    else if (vbat < vpreset) state_d = S_CC;
                    else                     state_d = S_CV;
                end
                S_TC, S_CC, S_CV: begin
                    if (temp_qual)                     state_d = S_FAULT;
                    else if (timeout && state == S_TC) state_d = S_FAULT;
                    else if (timeout && state == S_CV) state_d = S_END;
                    else if (prog_qual)                state_d = (state == S_TC) ? S_CC :
                                                                 (state == S_CC) ? S_CV : S_END;
                end
                S_END:   if (prog_qual) state_d = S_CHECK;
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_OFF;
            endcase
        end
    end

    always_comb begin
        prog_cnt_d = '0;
        temp_cnt_d = '0;
        timer_d    = '0;
        if (state_d == state) begin
            if (prog_cond)            prog_cnt_d = (prog_cnt >= QUAL_SAT) ? QUAL_SAT : prog_cnt + 4'd1;
            if (charging && temp_bad) temp_cnt_d = (temp_cnt >= QUAL_SAT) ? QUAL_SAT : temp_cnt + 4'd1;
            if ((state == S_TC) || (state == S_CV)) timer_d = timer_inc;
        end
    end

    always_comb begin
        tc_d    = state_d == S_TC;
        cc_d    = state_d == S_CC;
        cv_d    = state_d == S_CV;
        done_d  = state_d == S_END;
        fault_d = state_d == S_FAULT;
        icode_d = '0;
        if (state_d == S_TC)                           icode_d = itc;
        else if ((state_d == S_CC) || (state_d == S_CV)) icode_d = icc;
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state    <= S_OFF;
            prog_cnt <= '0;
            temp_cnt <= '0;
            timer    <= '0;
            tc       <= 1'b0;
            cc       <= 1'b0;
            cv       <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
            icode    <= '0;
        end else begin
            state    <= state_d;
            prog_cnt <= prog_cnt_d;
            temp_cnt <= temp_cnt_d;
            timer    <= timer_d;
            tc       <= tc_d;
            cc       <= cc_d;
            cv       <= cv_d;
            done     <= done_d;
            fault    <= fault_d;
            icode    <= icode_d;
        end
    end
endmodule

// File: tb/tb_batcharger_ctrl.sv
// tb/tb_batcharger_ctrl.sv - randomized and directed checks of batcharger_ctrl against a behavioural charge model
module tb_batcharger_ctrl;
    localparam int ADC_W = 8, CODE_W = 8, TIMER_W = 16, QUAL = 4;
`ifdef BATCHARGER_TEMPMON_EN
    localparam bit TEMPMON = 1'b1;
`else
    localparam bit TEMPMON = 1'b0;
`endif
    localparam int M_OFF = 0, M_CHECK = 1, M_TC = 2, M_CC = 3, M_CV = 4, M_END = 5, M_FAULT = 6;

    logic clk = 1'b0;
    logic rstz, en;
    logic [ADC_W-1:0] vbat, ibat, vtemp, vcutoff, vpreset, vrecharge, iend, tmin, tmax;
    logic [CODE_W-1:0] itc, icc, icode;
    logic [TIMER_W-1:0] tc_tmax, cv_tmax;
    logic tc, cc, cv, done, fault;
    logic [2:0] state;

    int vectors = 0, miscompares = 0;
    int m_mode = 0, m_ps = 0, m_ts = 0, m_age = 0, m_icode = 0;

    always #5 clk = ~clk;

    batcharger_ctrl #(.ADC_W(ADC_W), .CODE_W(CODE_W), .TIMER_W(TIMER_W), .QUAL(QUAL)) dut (
        .clk(clk), .rstz(rstz), .en(en), .vbat(vbat), .ibat(ibat), .vtemp(vtemp),
        .vcutoff(vcutoff), .vpreset(vpreset), .vrecharge(vrecharge), .iend(iend),
        .tmin(tmin), .tmax(tmax), .itc(itc), .icc(icc), .tc_tmax(tc_tmax), .cv_tmax(cv_tmax),
        .tc(tc), .cc(cc), .cv(cv), .icode(icode), .done(done), .fault(fault), .state(state)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit temp_out();
        return TEMPMON && ((int'(vtemp) < int'(tmin)) || (int'(vtemp) > int'(tmax)));
    endfunction

    // Model: count how long each condition has held and how long we've been in the mode.
    task automatic model_step();
        int nxt, ps, ts;
        bit cond;
        nxt = m_mode;
        ps = 0;
        ts = 0;
        if (!en) nxt = M_OFF;
        else if (m_mode == M_OFF) nxt = M_CHECK;
        else if (m_mode == M_CHECK) begin
            if (temp_out()) nxt = M_FAULT;
            else if (int'(vbat) < int'(vcutoff)) nxt = M_TC;
            else if (int'(vbat) < int'(vpreset)) nxt = M_CC;
            else nxt = M_CV;
        end else if (m_mode == M_TC || m_mode == M_CC || m_mode == M_CV || m_mode == M_END) begin
            case (m_mode)
                M_TC:    cond = int'(vbat) >= int'(vcutoff);
                M_CC:    cond = int'(vbat) >= int'(vpreset);
                M_CV:    cond = int'(ibat) < int'(iend);
                default: cond = int'(vbat) < int'(vrecharge);
            endcase
            ps = cond ? m_ps + 1 : 0;
            ts = (m_mode != M_END && temp_out()) ? m_ts + 1 : 0;
            if (ts >= QUAL) nxt = M_FAULT;
            else if (m_mode == M_TC && tc_tmax != 0 && m_age + 1 >= int'(tc_tmax)) nxt = M_FAULT;
            else if (m_mode == M_CV && cv_tmax != 0 && m_age + 1 >= int'(cv_tmax)) nxt = M_END;
            else if (ps >= QUAL) nxt = m_mode + 1;
            if (m_mode == M_END && ps >= QUAL) nxt = M_CHECK;
        end
        if (nxt != m_mode) begin
            m_ps = 0; m_ts = 0; m_age = 0;
        end else begin
            m_ps = ps; m_ts = ts; m_age = m_age + 1;
        end
        m_mode = nxt;
        m_icode = (m_mode == M_TC) ? int'(itc) : (m_mode == M_CC || m_mode == M_CV) ? int'(icc) : 0;
    endtask

    task automatic compare_model();
        chk("state", int'(state), m_mode);
        chk("tc", int'(tc), int'(m_mode == M_TC));
        chk("cc", int'(cc), int'(m_mode == M_CC));
        chk("cv", int'(cv), int'(m_mode == M_CV));
        chk("done", int'(done), int'(m_mode == M_END));
        chk("fault", int'(fault), int'(m_mode == M_FAULT));
        chk("icode", int'(icode), m_icode);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic model_reset();
        m_mode = M_OFF; m_ps = 0; m_ts = 0; m_age = 0; m_icode = 0;
    endtask

    initial begin
        rstz = 1'b0; en = 1'b0;
        vbat = 8'd50; ibat = 8'd50; vtemp = 8'd100; tmin = 8'd10; tmax = 8'd200;
        vcutoff = 8'd100; vpreset = 8'd200; vrecharge = 8'd180; iend = 8'd10;
        itc = 8'h10; icc = 8'h80; tc_tmax = '0; cv_tmax = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", int'(state), 0);
        chk("reset_outs", int'({tc, cc, cv, done, fault}), 0);
        chk("reset_icode", int'(icode), 0);
        model_reset();
        rstz = 1'b1;

        // Startup into TC
        en = 1'b1;
        cycle(); chk("start_check", int'(state), 1);
        cycle(); chk("start_tc", int'(state), 2); chk("start_icode", int'(icode), 16);
        // Broken qualification, then full qualification
        vbat = 8'd120; repeat (3) cycle();
        vbat = 8'd90; cycle(); chk("tc_hold", int'(state), 2);
        vbat = 8'd120; repeat (3) cycle(); chk("tc_3of4", int'(state), 2);
        cycle(); chk("to_cc", int'(state), 3); chk("cc_icode", int'(icode), 128);
        // CC -> CV -> END -> CHECK -> CC
        vbat = 8'd210; repeat (4) cycle(); chk("to_cv", int'(state), 4);
        ibat = 8'd5; repeat (4) cycle(); chk("to_end", int'(state), 5);
        chk("end_done", int'(done), 1); chk("end_icode", int'(icode), 0);
        vbat = 8'd170; repeat (4) cycle(); chk("recharge_check", int'(state), 1);
        cycle(); chk("recharge_cc", int'(state), 3);
        ibat = 8'd50;
        // TC timeout
        en = 1'b0; cycle();
        vbat = 8'd50; tc_tmax = 16'd1000; en = 1'b1;
        cycle(); cycle(); chk("tmo_tc", int'(state), 2);
        repeat (999) cycle(); chk("tmo_999", int'(state), 2);
        cycle(); chk("tmo_fault", int'(state), 6); chk("tmo_fault_flag", int'(fault), 1); chk("tmo_tc_flag", int'(tc), 0);
        tc_tmax = '0;
        repeat (3) cycle(); chk("fault_sticky", int'(state), 6);
        en = 1'b0; cycle(); chk("fault_exit", int'(state), 0);
        // Temperature excursion in CC
        en = 1'b1; vbat = 8'd150; cycle(); cycle(); chk("temp_cc", int'(state), 3);
        vtemp = 8'd220; repeat (4) cycle(); chk("temp_result", int'(state), TEMPMON ? 6 : 3);
        vtemp = 8'd100; en = 1'b0; cycle();
        // Async reset mid-CV
        en = 1'b1; vbat = 8'd210; cycle(); cycle(); chk("rst_cv", int'(state), 4);
        #2 rstz = 1'b0;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_outs", int'({tc, cc, cv, done, fault}), 0);
        chk("async_icode", int'(icode), 0);
        model_reset();
        rstz = 1'b1;
        cycle(); vbat = 8'd150; cycle(); chk("post_rst_cc", int'(state), 3);
        en = 1'b0; cycle(); chk("en_low_off", int'(state), 0);
        en = 1'b1; cycle(); chk("en_check", int'(state), 1);
        cycle(); chk("en_cc", int'(state), 3);

        // Randomized run against the model
        for (int n = 0; n < 5000; n++) begin
            if ($urandom_range(7) == 0) vbat = 8'($urandom_range(255));
            if ($urandom_range(7) == 0) ibat = 8'($urandom_range(60));
            if ($urandom_range(15) == 0)
                vtemp = ($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(190, 20));
            en = ($urandom_range(63) != 0);
            if ($urandom_range(99) == 0) begin
                vcutoff = 8'($urandom_range(120, 40));
                vpreset = 8'($urandom_range(230, 120));
                vrecharge = 8'($urandom_range(220, 100));
                iend = 8'($urandom_range(30));
                tc_tmax = ($urandom_range(2) == 0) ? 16'd0 : 16'($urandom_range(200, 1));
                cv_tmax = ($urandom_range(2) == 0) ? 16'd0 : 16'($urandom_range(200, 1));
            end
            if ($urandom_range(31) == 0) begin
                itc = 8'($urandom_range(255));
                icc = 8'($urandom_range(255));
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
